// File: rtl/image_mode_sched.sv
// Frame-synchronous image_mode scheduler: arbitrates host/button mode requests,
// commits the winner on a vs rising edge, and measures input frame geometry.
module image_mode_sched #(
  parameter logic [7:0]  DEFAULT_MODE = 8'h00,
  parameter int unsigned HOLD_FRAMES  = 2,
  parameter int unsigned CNT_W        = 12
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             vs_i,
  input  logic             de_i,
  input  logic             req_a_i,
  input  logic [7:0]       mode_a_i,
  output logic             ack_a_o,
  input  logic             req_b_i,
  input  logic [7:0]       mode_b_i,
  output logic             ack_b_o,
  output logic [7:0]       image_mode_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] width_o,
  output logic [CNT_W-1:0] height_o,
  output logic             geom_valid_o
);

  localparam int unsigned HOLD_W = 4;
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'((HOLD_FRAMES == 0) ? 0 : HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state;
  logic              vs_d;
  logic              de_d;
  logic              ack_a_d;
  logic              ack_b_d;
  logic              rr_b;
  logic              sel_b;
  logic [7:0]        mode_lat;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CNT_W-1:0]  pix_cnt;
  logic [CNT_W-1:0]  line_cnt;
  logic [CNT_W-1:0]  line_w;
  logic              fs_seen;

  logic fs;
  logic le;
  logic req_a_ok;
  logic req_b_ok;
  logic grant_b;

  assign fs = vs_i & ~vs_d;
  assign le = de_d & ~de_i;

  // A requester is blind while its ack is out and for one cycle after.
  assign req_a_ok = req_a_i & ~(ack_a_o | ack_a_d);
  assign req_b_ok = req_b_i & ~(ack_b_o | ack_b_d);

  always_comb begin
    grant_b = req_b_ok;
    if (req_a_ok && req_b_ok) begin
      grant_b = rr_b;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vs_d    <= 1'b0;
      de_d    <= 1'b0;
      ack_a_d <= 1'b0;
      ack_b_d <= 1'b0;
    end else begin
      vs_d    <= vs_i;
      de_d    <= de_i;
      ack_a_d <= ack_a_o;
      ack_b_d <= ack_b_o;
    end
  end

  // Arbitration / commit / hold-off sequencing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rr_b         <= 1'b0;
      sel_b        <= 1'b0;
      mode_lat     <= DEFAULT_MODE;
      hold_cnt     <= '0;
      image_mode_o <= DEFAULT_MODE;
      ack_a_o      <= 1'b0;
      ack_b_o      <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      ack_a_o <= 1'b0;
      ack_b_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_a_ok || req_b_ok) begin
            sel_b    <= grant_b;
            mode_lat <= grant_b ? mode_b_i : mode_a_i;
            if (req_a_ok && req_b_ok) begin
              rr_b <= ~rr_b;
            end
            state  <= PEND;
            busy_o <= 1'b1;
          end
        end
        PEND: begin
          if (fs) begin
            image_mode_o <= mode_lat;
            ack_a_o      <= ~sel_b;
            ack_b_o      <= sel_b;
            hold_cnt     <= '0;
            if (HOLD_FRAMES == 0) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          // The commit frame start is not counted; only later ones are.
          if (fs) begin
            if (hold_cnt == HOLD_LAST) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Frame geometry: saturating pixel/line counters reported at frame start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt      <= '0;
      line_cnt     <= '0;
      line_w       <= '0;
      fs_seen      <= 1'b0;
      width_o      <= '0;
      height_o     <= '0;
      geom_valid_o <= 1'b0;
    end else begin
      if (le) begin
        line_w  <= pix_cnt;
        pix_cnt <= '0;
      end else if (de_i && (pix_cnt != CNT_MAX)) begin
        pix_cnt <= pix_cnt + CNT_W'(1);
      end

      if (fs) begin
        width_o  <= line_w;
        height_o <= line_cnt;
        line_cnt <= '0;
        fs_seen  <= 1'b1;
        if (fs_seen) begin
          geom_valid_o <= 1'b1;
        end
      end else if (le && (line_cnt != CNT_MAX)) begin
        line_cnt <= line_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_image_mode_sched.sv
// Bench for image_mode_sched: two instances (hold=2/12-bit, hold=0/3-bit) against
// a transaction-level model, plus directed scenarios with literal expectations.
module tb_image_mode_sched;

  localparam int unsigned CW0 = 12;
  localparam int unsigned CW1 = 3;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic vs      = 1'b0;
  logic de      = 1'b0;

  // [instance][side] with side 0 = A (host), 1 = B (button)
  logic       req  [2][2];
  logic [7:0] mode [2][2];
  logic       ack  [2][2];
  logic [7:0] imode[2];
  logic       busy [2];
  logic       gv   [2];
  logic [CW0-1:0] width0, height0;
  logic [CW1-1:0] width1, height1;

  always #5 clock = ~clock;

  image_mode_sched #(.DEFAULT_MODE(8'h00), .HOLD_FRAMES(2), .CNT_W(CW0)) dut (
    .clock(clock), .reset_n(reset_n), .vs_i(vs), .de_i(de),
    .req_a_i(req[0][0]), .mode_a_i(mode[0][0]), .ack_a_o(ack[0][0]),
    .req_b_i(req[0][1]), .mode_b_i(mode[0][1]), .ack_b_o(ack[0][1]),
    .image_mode_o(imode[0]), .busy_o(busy[0]),
    .width_o(width0), .height_o(height0), .geom_valid_o(gv[0])
  );

  image_mode_sched #(.DEFAULT_MODE(8'h00), .HOLD_FRAMES(0), .CNT_W(CW1)) dut0 (
    .clock(clock), .reset_n(reset_n), .vs_i(vs), .de_i(de),
    .req_a_i(req[1][0]), .mode_a_i(mode[1][0]), .ack_a_o(ack[1][0]),
    .req_b_i(req[1][1]), .mode_b_i(mode[1][1]), .ack_b_o(ack[1][1]),
    .image_mode_o(imode[1]), .busy_o(busy[1]),
    .width_o(width1), .height_o(height1), .geom_valid_o(gv[1])
  );

  // ---------------- behavioural model ----------------
  int hold_frames[2] = '{2, 0};
  int cmax[2]        = '{4095, 7};

  bit m_wait[2];
  int m_hold_left[2];
  bit m_gid[2];
  int m_gmode[2];
  bit m_rr[2];
  int ack_cyc[2][2];
  int cyc = 0;
  int m_pix[2], m_line[2], m_lw[2];
  bit m_seen[2];
  bit m_vsp, m_dep, m_fs, m_le, a_ok, b_ok, take_b;

  int e_mode[2], e_w[2], e_h[2];
  bit e_ack[2][2], e_busy[2], e_gv[2];

  function automatic bit masked(int i, int s);
    return (cyc == ack_cyc[i][s]) || (cyc == ack_cyc[i][s] + 1);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_wait[i] = 0; m_hold_left[i] = 0; m_gid[i] = 0; m_gmode[i] = 0; m_rr[i] = 0;
        ack_cyc[i][0] = -100; ack_cyc[i][1] = -100;
        m_pix[i] = 0; m_line[i] = 0; m_lw[i] = 0; m_seen[i] = 0;
        e_mode[i] = 0; e_w[i] = 0; e_h[i] = 0;
        e_ack[i][0] = 0; e_ack[i][1] = 0; e_busy[i] = 0; e_gv[i] = 0;
      end
      m_vsp = 0; m_dep = 0;
    end else begin
      m_fs = vs && !m_vsp;
      m_le = m_dep && !de;
      for (int i = 0; i < 2; i++) begin
        e_ack[i][0] = 0; e_ack[i][1] = 0;
        if (m_wait[i]) begin
          if (m_fs) begin
            e_mode[i] = m_gmode[i];
            e_ack[i][m_gid[i]] = 1;
            ack_cyc[i][m_gid[i]] = cyc + 1;
            m_wait[i] = 0;
            m_hold_left[i] = hold_frames[i];
          end
        end else if (m_hold_left[i] > 0) begin
          if (m_fs) m_hold_left[i]--;
        end else begin
          a_ok = req[i][0] && !masked(i, 0);
          b_ok = req[i][1] && !masked(i, 1);
          if (a_ok && b_ok) begin
            take_b = m_rr[i];
            m_rr[i] = !m_rr[i];
          end else begin
            take_b = b_ok;
          end
          if (a_ok || b_ok) begin
            m_wait[i] = 1;
            m_gid[i] = take_b;
            m_gmode[i] = take_b ? int'(mode[i][1]) : int'(mode[i][0]);
          end
        end
        e_busy[i] = m_wait[i] || (m_hold_left[i] > 0);

        if (m_fs) begin
          e_w[i] = m_lw[i];
          e_h[i] = m_line[i];
          m_line[i] = 0;
          if (m_seen[i]) e_gv[i] = 1;
          m_seen[i] = 1;
        end
        if (m_le) begin
          m_lw[i] = m_pix[i];
          m_pix[i] = 0;
          if (!m_fs && m_line[i] < cmax[i]) m_line[i]++;
        end else if (de && m_pix[i] < cmax[i]) begin
          m_pix[i]++;
        end
      end
      m_vsp = vs;
      m_dep = de;
      cyc++;
    end
  end

  // ---------------- frame generator ----------------
  bit gen_en = 0;
  bit rand_frames = 0;
  int fw, fl, fv;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    wait (gen_en);
    @(posedge clock);
    #1;
    forever begin
      if (rand_frames) begin
        fw = int'($urandom_range(1, 10));
        fl = int'($urandom_range(1, 9));
        fv = ($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(1, 4));
      end else begin
        fw = 8; fl = 4; fv = 2;
      end
      vs = 1'b1; tick(fv);
      vs = 1'b0; tick(3);
      for (int l = 0; l < fl; l++) begin
        de = 1'b1; tick(fw);
        de = 1'b0; tick(3);
      end
      tick(4);
    end
  end

  // ---------------- checking / stimulus ----------------
  int checks = 0;
  int failures = 0;
  bit vs_last = 0;
  bit rose = 0;
  int drop_cnt[2][2];
  int extra[2][2];

  task automatic cmp(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      cmp($sformatf("i%0d.image_mode", i), 32'(imode[i]), e_mode[i]);
      cmp($sformatf("i%0d.ack_a", i), 32'(ack[i][0]), int'(e_ack[i][0]));
      cmp($sformatf("i%0d.ack_b", i), 32'(ack[i][1]), int'(e_ack[i][1]));
      cmp($sformatf("i%0d.busy", i), 32'(busy[i]), int'(e_busy[i]));
      cmp($sformatf("i%0d.geom_valid", i), 32'(gv[i]), int'(e_gv[i]));
    end
    cmp("i0.width", 32'(width0), e_w[0]);
    cmp("i0.height", 32'(height0), e_h[0]);
    cmp("i1.width", 32'(width1), e_w[1]);
    cmp("i1.height", 32'(height1), e_h[1]);
  endtask

  // One cycle: check outputs, then requesters release after ack (+extra cycles).
  task automatic step();
    @(negedge clock);
    compare_all();
    rose = vs && !vs_last;
    vs_last = vs;
    for (int i = 0; i < 2; i++) begin
      for (int s = 0; s < 2; s++) begin
        if (ack[i][s] === 1'b1 && req[i][s] && drop_cnt[i][s] < 0) drop_cnt[i][s] = extra[i][s];
        if (drop_cnt[i][s] == 0) begin
          req[i][s] = 1'b0;
          drop_cnt[i][s] = -1;
        end else if (drop_cnt[i][s] > 0) begin
          drop_cnt[i][s]--;
        end
      end
    end
  endtask

  // Returns in the first cycle after a frame-start edge.
  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!rose && n < 1000);
    if (!rose) begin
      checks++;
      failures++;
      $display("FAIL wait_fs timeout actual=%0d cycles expected=vs rise t=%0t", n, $time);
    end
    step();
  endtask

  function automatic logic [7:0] pick_mode();
    case ($urandom_range(0, 3))
      0: return 8'h00;
      1: return 8'h01;
      2: return 8'h05;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 2; i++)
      for (int s = 0; s < 2; s++) begin
        req[i][s] = 1'b0; mode[i][s] = 8'h00; drop_cnt[i][s] = -1; extra[i][s] = 0;
      end

    // reset state
    repeat (3) step();
    cmp("lit_reset_mode", 32'(imode[0]), 8'h00);
    cmp("lit_reset_busy", 32'(busy[0]), 0);
    cmp("lit_reset_ack_a", 32'(ack[0][0]), 0);
    reset_n = 1'b1;
    gen_en = 1;

    // geometry of 8x4 frames; 3-bit instance saturates width at 7
    wait_fs();
    wait_fs();
    cmp("lit_width", 32'(width0), 8);
    cmp("lit_height", 32'(height0), 4);
    cmp("lit_geom_valid", 32'(gv[0]), 1);
    cmp("lit_width_sat", 32'(width1), 7);
    cmp("lit_height_cw3", 32'(height1), 4);

    // single A request mid-frame
    repeat (20) step();
    req[0][0] = 1'b1; mode[0][0] = 8'h01;
    step();
    cmp("lit_busy_after_req", 32'(busy[0]), 1);
    wait_fs();
    cmp("lit_commit_mode", 32'(imode[0]), 8'h01);
    cmp("lit_ack_a_pulse", 32'(ack[0][0]), 1);
    step();
    cmp("lit_ack_a_one_cycle", 32'(ack[0][0]), 0);
    cmp("lit_busy_hold", 32'(busy[0]), 1);
    wait_fs();
    cmp("lit_busy_hold1", 32'(busy[0]), 1);
    wait_fs();
    cmp("lit_busy_released", 32'(busy[0]), 0);

    // simultaneous A/B out of reset: A at fs#1, B at fs#4
    reset_n = 1'b0;
    step();
    req[0][0] = 1'b1; mode[0][0] = 8'h01;
    req[0][1] = 1'b1; mode[0][1] = 8'h00;
    reset_n = 1'b1;
    wait_fs();
    cmp("lit_rr_a_first", 32'(imode[0]), 8'h01);
    cmp("lit_rr_ack_a", 32'(ack[0][0]), 1);
    wait_fs();
    wait_fs();
    wait_fs();
    cmp("lit_rr_b_mode", 32'(imode[0]), 8'h00);
    cmp("lit_rr_ack_b", 32'(ack[0][1]), 1);

    // B request dropped during hold is discarded
    repeat (3) step();
    req[0][1] = 1'b1; mode[0][1] = 8'h05;
    repeat (3) step();
    req[0][1] = 1'b0;
    repeat (3) wait_fs();
    cmp("lit_dropped_req_mode", 32'(imode[0]), 8'h00);

    // reset while pending: lost, then re-request completes
    req[0][0] = 1'b1; mode[0][0] = 8'h01;
    step();
    step();
    cmp("lit_pend_busy", 32'(busy[0]), 1);
    reset_n = 1'b0;
    req[0][0] = 1'b0;
    step();
    cmp("lit_rst_mode", 32'(imode[0]), 8'h00);
    cmp("lit_rst_busy", 32'(busy[0]), 0);
    reset_n = 1'b1;
    wait_fs();
    cmp("lit_rst_no_commit", 32'(imode[0]), 8'h00);
    req[0][0] = 1'b1;
    step();
    wait_fs();
    cmp("lit_rereq_mode", 32'(imode[0]), 8'h01);
    cmp("lit_rereq_ack", 32'(ack[0][0]), 1);

    // zero-hold instance: stale req level after ack must not re-grant
    extra[1][0] = 2;
    req[1][0] = 1'b1; mode[1][0] = 8'h05;
    step();
    wait_fs();
    cmp("lit_h0_mode", 32'(imode[1]), 8'h05);
    cmp("lit_h0_ack", 32'(ack[1][0]), 1);
    for (int k = 0; k < 3; k++) begin
      step();
      cmp($sformatf("lit_h0_no_regrant%0d", k), 32'(busy[1]), 0);
    end
    extra[1][0] = 0;
    req[1][0] = 1'b1; mode[1][0] = 8'h06;
    step();
    wait_fs();
    cmp("lit_h0_second_mode", 32'(imode[1]), 8'h06);

    // randomized traffic
    rand_frames = 1;
    for (int n = 0; n < 8000; n++) begin
      step();
      if ($urandom_range(0, 1999) == 0) begin
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
        for (int s = 0; s < 2; s++) begin
          if (!req[i][s]) begin
            if ($urandom_range(0, 24) == 0) begin
              req[i][s] = 1'b1;
              mode[i][s] = pick_mode();
              extra[i][s] = int'($urandom_range(0, 2));
            end
          end else if (drop_cnt[i][s] < 0 && $urandom_range(0, 79) == 0) begin
            req[i][s] = 1'b0;
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
